dma_read_master: RTL and testbench

//  AXI4-Full read master: fetches i_total_len bytes from i_src_addr in INCR bursts and pushes every beat into the DMA data FIFO.

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_burst_calc.sv | 24 ++
 rtl/dma_read_master.sv | 190 +++++++++++++++++++
 tb/tb_dma_read_master.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI encodings, 4KB boundary constant and the read-master state type.
package dma_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] BOUNDARY_4KB   = 32'h0000_1000;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_SPACE = 3'd1,
        S_AR         = 3'd2,
        S_R          = 3'd3,
        S_DONE       = 3'd4
    } rd_state_e;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing shared by the DMA masters: largest word count that fits the remaining
// length, the per-burst cap and the distance to the next 4KB page.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int C_BW_W = 5
) (
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_remaining,
    input  logic [31:0]       i_max_bytes,
    output logic [C_BW_W-1:0] o_burst_words
);

    logic [31:0] w_to_boundary;
    logic [31:0] w_bytes;

    // Clamp by remaining length, burst cap and bytes left in the current 4KB page
    always_comb begin
        w_to_boundary = BOUNDARY_4KB - (i_addr & (BOUNDARY_4KB - 32'd1));
        w_bytes       = min_u32(min_u32(i_remaining, i_max_bytes), w_to_boundary);
        o_burst_words = C_BW_W'(w_bytes >> 2);
    end

endmodule

// File: rtl/dma_read_master.sv
// AXI4 read master: fetches a byte range in INCR bursts and pushes each beat into the DMA FIFO.
// An AR is only issued once the FIFO can absorb the whole burst, so R never back-pressures.
module dma_read_master
    import dma_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_BYTES  = 64,
    parameter int C_FIFO_CNT_W       = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_start,
    input  logic [31:0]                   i_src_addr,
    input  logic [31:0]                   i_total_len,
    output logic                          o_busy,
    output logic                          o_read_done,
    output logic                          o_read_err,
    input  logic [C_FIFO_CNT_W-1:0]       i_fifo_free,
    output logic                          o_fifo_wr_en,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wdata,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int C_BW_W = $clog2(C_MAX_BURST_BYTES / 4) + 1;

    rd_state_e                     r_state;
    rd_state_e                     w_state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                   r_remaining;
    logic [C_BW_W-1:0]             r_burst_words;
    logic [C_BW_W-1:0]             r_beat_cnt;
    logic [C_BW_W-1:0]             w_burst_words;
    logic [7:0]                    r_arlen;
    logic                          r_arvalid;
    logic                          r_rready;
    logic                          r_busy;
    logic                          r_read_done;
    logic                          r_read_err;
    logic                          w_ar_hs;
    logic                          w_r_hs;
    logic                          w_last_beat;
    logic                          w_space_ok;
    logic [31:0]                   w_burst_bytes;
    logic [31:0]                   w_remaining_nxt;

    dma_burst_calc #(
        .C_BW_W (C_BW_W)
    ) u_burst_calc (
        .i_addr        (32'(r_addr)),
        .i_remaining   (r_remaining),
        .i_max_bytes   (32'(C_MAX_BURST_BYTES)),
        .o_burst_words (w_burst_words)
    );

    assign w_ar_hs         = r_arvalid & m_axi_arready;
    assign w_r_hs          = r_rready & m_axi_rvalid;
    assign w_last_beat     = (r_beat_cnt == (r_burst_words - C_BW_W'(1)));
    assign w_burst_bytes   = 32'(r_burst_words) << 2;
    assign w_remaining_nxt = r_remaining - w_burst_bytes;
    assign w_space_ok      = (32'(i_fifo_free) >= 32'(w_burst_words));

    // Next-state logic; the R phase ends on the beat counter, never on rlast
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if ((i_total_len & 32'hFFFF_FFFC) == 32'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT_SPACE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_SPACE: begin
                if (w_space_ok) begin
                    w_state_nxt = S_AR;
                end else begin
                    w_state_nxt = S_WAIT_SPACE;
                end
            end
            S_AR: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_R;
                end else begin
                    w_state_nxt = S_AR;
                end
            end
            S_R: begin
                if (w_r_hs && w_last_beat) begin
                    if (w_remaining_nxt == 32'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT_SPACE;
                    end
                end else begin
                    w_state_nxt = S_R;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered handshake/status outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_read_done <= 1'b0;
        end else begin
            r_arvalid   <= (w_state_nxt == S_AR);
            r_rready    <= (w_state_nxt == S_R);
            r_busy      <= (w_state_nxt == S_WAIT_SPACE) || (w_state_nxt == S_AR) || (w_state_nxt == S_R);
            r_read_done <= (w_state_nxt == S_DONE);
        end
    end

    // Transfer bookkeeping: address, remaining bytes, burst parameters, beat count, error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_remaining   <= 32'd0;
            r_burst_words <= '0;
            r_beat_cnt    <= '0;
            r_arlen       <= 8'd0;
            r_read_err    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_addr      <= C_M_AXI_ADDR_WIDTH'(i_src_addr);
                r_remaining <= i_total_len & 32'hFFFF_FFFC;
                r_beat_cnt  <= '0;
                r_read_err  <= 1'b0;
            end
            if ((r_state == S_WAIT_SPACE) && w_space_ok) begin
                r_burst_words <= w_burst_words;
                r_arlen       <= 8'(w_burst_words - C_BW_W'(1));
            end
            if ((r_state == S_R) && w_r_hs) begin
                // Bad response or misplaced rlast is flagged but the data is still kept
                if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != w_last_beat)) begin
                    r_read_err <= 1'b1;
                end
                if (w_last_beat) begin
                    r_beat_cnt  <= '0;
                    r_addr      <= r_addr + C_M_AXI_ADDR_WIDTH'(w_burst_bytes);
                    r_remaining <= w_remaining_nxt;
                end else begin
                    r_beat_cnt  <= r_beat_cnt + C_BW_W'(1);
                end
            end
        end
    end

    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign o_fifo_wr_en  = w_r_hs;
    assign o_fifo_wdata  = m_axi_rdata;
    assign o_busy        = r_busy;
    assign o_read_done   = r_read_done;
    assign o_read_err    = r_read_err;

endmodule

// File: tb/tb_dma_read_master.sv
// Bench for dma_read_master: AXI slave model with optional stalls, AR/data scoreboards,
// a vector table of transfers and hand-written corner-case sequences.
module tb_dma_read_master;

    logic        clk;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_src_addr;
    logic [31:0] i_total_len;
    logic        o_busy;
    logic        o_read_done;
    logic        o_read_err;
    logic [5:0]  i_fifo_free;
    logic        o_fifo_wr_en;
    logic [31:0] o_fifo_wdata;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    dma_read_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_src_addr    (i_src_addr),
        .i_total_len   (i_total_len),
        .o_busy        (o_busy),
        .o_read_done   (o_read_done),
        .o_read_err    (o_read_err),
        .i_fifo_free   (i_fifo_free),
        .o_fifo_wr_en  (o_fifo_wr_en),
        .o_fifo_wdata  (o_fifo_wdata),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] len;
        logic [5:0]  free;
        bit          stall;
        int          err_burst;
        int          err_beat;
        int          bad_last_burst;
        int          exp_bursts;
        int          exp_pushes;
        bit          exp_err;
    } vec_t;

    ar_t         exp_ar_q[$];
    logic [31:0] exp_data_q[$];
    vec_t        vecs[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ar_cnt   = 0;
    int push_cnt = 0;

    bit          stall          = 1'b0;
    int          err_burst      = -1;
    int          err_beat       = -1;
    int          bad_last_burst = -1;
    bit          slv_active     = 1'b0;
    bit          r_hold         = 1'b0;
    bit          ar_wait        = 1'b0;
    logic [31:0] ar_addr_s;
    logic [7:0]  ar_len_s;
    logic [31:0] slv_addr       = 32'd0;
    int          slv_len        = 0;
    int          slv_beat       = 0;
    int          slv_burst      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent burst-splitting model: page boundary and 64-byte cap
    task automatic build_expect(input logic [31:0] addr, input logic [31:0] len);
        logic [31:0] a;
        logic [31:0] rem;
        logic [31:0] bytes;
        logic [31:0] to_pg;
        ar_t         e;
        a   = addr;
        rem = len & 32'hFFFF_FFFC;
        while (rem != 32'd0) begin
            bytes = (rem > 32'd64) ? 32'd64 : rem;
            to_pg = 32'd4096 - (a % 32'd4096);
            if (bytes > to_pg) bytes = to_pg;
            e.addr = a;
            e.len  = 8'((bytes / 32'd4) - 32'd1);
            exp_ar_q.push_back(e);
            for (int i = 0; i < int'(bytes / 32'd4); i++) exp_data_q.push_back(mem(a + 32'(i) * 32'd4));
            a   = a + bytes;
            rem = rem - bytes;
        end
    endtask

    // AXI slave model and monitors: drive on negedge, evaluate the coming edge's handshakes 1ns later
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
        m_axi_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_rresp   = 2'b00;
                slv_active    = 1'b0;
                r_hold        = 1'b0;
                ar_wait       = 1'b0;
            end else begin
                m_axi_arready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (!r_hold) m_axi_rvalid = slv_active && (!stall || ($urandom_range(0, 2) != 0));
                m_axi_rdata = mem(slv_addr + 32'(slv_beat) * 32'd4);
                m_axi_rresp = (slv_burst == err_burst && slv_beat == err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast = (slv_beat == slv_len) != (slv_burst == bad_last_burst && slv_beat == slv_len);
                #1;
                if (ar_wait) begin
                    check("ar_valid_held", m_axi_arvalid, 1'b1);
                    check("ar_addr_stable", m_axi_araddr, ar_addr_s);
                    check("ar_len_stable", m_axi_arlen, ar_len_s);
                end
                ar_wait   = m_axi_arvalid && !m_axi_arready;
                ar_addr_s = m_axi_araddr;
                ar_len_s  = m_axi_arlen;
                if (o_fifo_wr_en) begin
                    push_cnt++;
                    check("push_expected", 64'(exp_data_q.size() > 0), 64'd1);
                    if (exp_data_q.size() > 0) check("push_data", o_fifo_wdata, exp_data_q.pop_front());
                end
                r_hold = m_axi_rvalid && !m_axi_rready;
                if (m_axi_rvalid && m_axi_rready) begin
                    if (slv_beat == slv_len) slv_active = 1'b0;
                    slv_beat++;
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_t e;
                    check("single_outstanding", slv_active, 1'b0);
                    check("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {3'b010, 2'b01});
                    check("ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
                    if (exp_ar_q.size() > 0) begin
                        e = exp_ar_q.pop_front();
                        check("ar_addr", m_axi_araddr, e.addr);
                        check("ar_len", m_axi_arlen, e.len);
                    end
                    slv_addr   = m_axi_araddr;
                    slv_len    = int'(m_axi_arlen);
                    slv_beat   = 0;
                    slv_burst  = ar_cnt;
                    ar_cnt++;
                    slv_active = 1'b1;
                end
            end
        end
    end

    task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len);
        build_expect(addr, len);
        ar_cnt   = 0;
        push_cnt = 0;
        @(negedge clk);
        i_src_addr  = addr;
        i_total_len = len;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #2;
        check("err_cleared_on_start", o_read_err, 1'b0);
        check("busy_after_start", o_busy, 64'((len & 32'hFFFF_FFFC) != 32'd0));
    endtask

    task automatic finish_xfer(input string name, input int exp_b, input int exp_p, input bit exp_err, input int max_cyc);
        int cyc;
        cyc = 0;
        while (!o_read_done && cyc < max_cyc) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check({name, "_done"}, o_read_done, 1'b1);
        check({name, "_busy_low_at_done"}, o_busy, 1'b0);
        check({name, "_bursts"}, 64'(ar_cnt), 64'(exp_b));
        check({name, "_pushes"}, 64'(push_cnt), 64'(exp_p));
        check({name, "_err"}, o_read_err, exp_err);
        check({name, "_sb_empty"}, 64'(exp_ar_q.size() + exp_data_q.size()), 64'd0);
        @(negedge clk);
        #2;
        check({name, "_done_one_cycle"}, o_read_done, 1'b0);
    endtask

    initial begin
        int w;
        int seen;
        reset_n     = 1'b0;
        i_start     = 1'b0;
        i_src_addr  = 32'd0;
        i_total_len = 32'd0;
        i_fifo_free = 6'd16;

        //         name         addr          len     free  stl errB errBt badL  bursts pushes err
        vecs.push_back('{"basic",    32'h0000_1000, 32'd256, 6'd16, 1'b0, -1, -1, -1, 4, 64, 1'b0});
        vecs.push_back('{"pg_split", 32'h0000_0FF8, 32'd40,  6'd16, 1'b0, -1, -1, -1, 2, 10, 1'b0});
        vecs.push_back('{"stalls",   32'h0000_2000, 32'd100, 6'd63, 1'b1, -1, -1, -1, 2, 25, 1'b0});
        vecs.push_back('{"rresp",    32'h0000_6000, 32'd64,  6'd16, 1'b0,  0,  3, -1, 1, 16, 1'b1});
        vecs.push_back('{"err_clr",  32'h0000_7000, 32'd16,  6'd16, 1'b0, -1, -1, -1, 1, 4,  1'b0});
        vecs.push_back('{"pg_stall", 32'h0000_0FE0, 32'd200, 6'd63, 1'b1, -1, -1, -1, 4, 50, 1'b0});
        vecs.push_back('{"len0",     32'h0000_9000, 32'd0,   6'd16, 1'b0, -1, -1, -1, 0, 0,  1'b0});
        vecs.push_back('{"len3",     32'h0000_9000, 32'd3,   6'd16, 1'b0, -1, -1, -1, 0, 0,  1'b0});
        vecs.push_back('{"no_rlast", 32'h0000_A000, 32'd32,  6'd16, 1'b0, -1, -1,  0, 1, 8,  1'b1});
        vecs.push_back('{"one_beat", 32'h0000_AFFC, 32'd8,   6'd16, 1'b0, -1, -1, -1, 2, 2,  1'b0});
        vecs.push_back('{"len7",     32'h0000_C000, 32'd7,   6'd16, 1'b0, -1, -1, -1, 1, 1,  1'b0});

        repeat (3) @(negedge clk);
        #2;
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_wr_en", o_fifo_wr_en, 1'b0);
        check("rst_flags", {o_busy, o_read_done, o_read_err}, 3'b000);
        check("rst_araddr_arlen", {m_axi_araddr, m_axi_arlen}, 40'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            i_fifo_free    = vecs[k].free;
            stall          = vecs[k].stall;
            err_burst      = vecs[k].err_burst;
            err_beat       = vecs[k].err_beat;
            bad_last_burst = vecs[k].bad_last_burst;
            start_xfer(vecs[k].addr, vecs[k].len);
            finish_xfer(vecs[k].name, vecs[k].exp_bursts, vecs[k].exp_pushes, vecs[k].exp_err,
                        (vecs[k].exp_bursts == 0) ? 2 : 3000);
        end
        stall          = 1'b0;
        err_burst      = -1;
        bad_last_burst = -1;

        // FIFO too full for the burst: AR must wait for space
        i_fifo_free = 6'd8;
        start_xfer(32'h0000_4000, 32'd64);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (m_axi_arvalid) seen++;
        end
        check("no_ar_low_free", 64'(seen), 64'd0);
        i_fifo_free = 6'd16;
        w = 0;
        while (!m_axi_arvalid && w < 4) begin
            @(negedge clk);
            #2;
            w++;
        end
        check("ar_after_space", m_axi_arvalid, 1'b1);
        check("ar_space_latency", 64'(w <= 2), 64'd1);
        finish_xfer("space_wait", 1, 16, 1'b0, 3000);

        // Start pulse while busy must not disturb the transfer
        start_xfer(32'h0000_3000, 32'd128);
        repeat (5) @(negedge clk);
        i_src_addr  = 32'h0000_8000;
        i_total_len = 32'd8;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        finish_xfer("ignore_start", 2, 32, 1'b0, 3000);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #2;
            if (o_read_done || o_busy) seen++;
        end
        check("no_second_xfer", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of a burst
        start_xfer(32'h0000_5000, 32'd64);
        w = 0;
        while (!o_fifo_wr_en && w < 20) begin
            @(negedge clk);
            #2;
            w++;
        end
        check("reset_mid_burst_reached", o_fifo_wr_en, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_arvalid_rready", {m_axi_arvalid, m_axi_rready}, 2'b00);
        check("arst_wr_en", o_fifo_wr_en, 1'b0);
        check("arst_flags", {o_busy, o_read_done, o_read_err}, 3'b000);
        exp_ar_q.delete();
        exp_data_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_xfer(32'h0000_5100, 32'd16);
        finish_xfer("after_reset", 1, 4, 1'b0, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
